// File: rtl/bg_mean_estimator_if.sv
// Background-sample pixel stream between a pixel source and the
// mean estimator: valid/ready handshake plus one RGB sample.
interface bg_mean_estimator_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] red_in;
  logic [7:0] green_in;
  logic [7:0] blue_in;

  modport master (
    output pix_valid,
    output red_in,
    output green_in,
    output blue_in,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  red_in,
    input  green_in,
    input  blue_in,
    output pix_ready
  );
endinterface

// File: rtl/bg_mean_estimator.sv
// Averages NUM_PIXELS RGB background samples with a bit-serial divider.
// Define BG_EST_ROUND_EN for round-half-up instead of floor.
module bg_mean_estimator #(
  parameter int NUM_PIXELS = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Ack,
  bg_mean_estimator_if.slave  pix,
  output logic [8:0]          red_exp,
  output logic [8:0]          green_exp,
  output logic [8:0]          blue_exp,
  output logic                Done,
  output logic                Qi,
  output logic                Qa,
  output logic                Qd,
  output logic                Qdn
);

  localparam int CW    = $clog2(NUM_PIXELS + 1);
  localparam int SUM_W = 8 + CW;
  localparam int RW    = CW + 1;
  localparam int DW    = $clog2(SUM_W);

  localparam logic [CW-1:0] LAST_C = CW'(NUM_PIXELS - 1);
  localparam logic [RW-1:0] DIV_R  = RW'(NUM_PIXELS);
  localparam logic [DW-1:0] LAST_D = DW'(SUM_W - 1);

`ifdef BG_EST_ROUND_EN
  localparam logic [SUM_W-1:0] RND = SUM_W'(NUM_PIXELS / 2);
`else
  localparam logic [SUM_W-1:0] RND = '0;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_ACCUM  = 4'b0010,
    S_DIVIDE = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]            cnt_q;
  logic [DW-1:0]            div_q;
  logic [2:0][SUM_W-1:0]    sum_q;
  logic [2:0][CW-1:0]       rem_q;
  logic [2:0][7:0]          exp_q;
  logic [2:0][7:0]          px;

  logic                     acc;
  logic                     last_px;
  logic                     last_div;
  logic [2:0][RW-1:0]       trial;
  logic [2:0]               ge;
  logic [2:0][CW-1:0]       rem_nx;
  logic [2:0][SUM_W-1:0]    quo_nx;

  assign px = {pix.blue_in, pix.green_in, pix.red_in};

  assign Qi  = state_q[0];
  assign Qa  = state_q[1];
  assign Qd  = state_q[2];
  assign Qdn = state_q[3];

  assign Done          = state_q[3];
  assign pix.pix_ready = state_q[1];

  assign red_exp   = {1'b0, exp_q[0]};
  assign green_exp = {1'b0, exp_q[1]};
  assign blue_exp  = {1'b0, exp_q[2]};

  assign acc      = state_q[1] & pix.pix_valid;
  assign last_px  = acc & (cnt_q == LAST_C);
  assign last_div = state_q[2] & (div_q == LAST_D);

  // The sum register doubles as the dividend/quotient shift register.
  always_comb begin
    trial  = '0;
    ge     = '0;
    rem_nx = '0;
    quo_nx = '0;
    for (int c = 0; c < 3; c++) begin
      trial[c]  = {rem_q[c], sum_q[c][SUM_W-1]};
      ge[c]     = trial[c] >= DIV_R;
      rem_nx[c] = ge[c] ? CW'(trial[c] - DIV_R)
                        : CW'(trial[c]);
      quo_nx[c] = {sum_q[c][SUM_W-2:0], ge[c]};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[0]: if (Start)    state_d = S_ACCUM;
      state_q[1]: if (last_px)  state_d = S_DIVIDE;
      state_q[2]: if (last_div) state_d = S_DONE;
      state_q[3]: if (Ack)      state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      div_q <= '0;
      sum_q <= '0;
      rem_q <= '0;
      exp_q <= '0;
    end else begin
      if (state_q[0] && Start) begin
        cnt_q <= '0;
        sum_q <= '0;
      end
      if (acc) begin
        cnt_q <= cnt_q + CW'(1);
        // Rounding bias rides in with the final sample.
        for (int c = 0; c < 3; c++) begin
          sum_q[c] <= sum_q[c] + SUM_W'(px[c])
                    + (RND & {SUM_W{last_px}});
        end
        if (last_px) begin
          rem_q <= '0;
          div_q <= '0;
        end
      end
      if (state_q[2]) begin
        sum_q <= quo_nx;
        rem_q <= rem_nx;
        div_q <= div_q + DW'(1);
        if (last_div) begin
          for (int c = 0; c < 3; c++) begin
            exp_q[c] <= quo_nx[c][7:0];
          end
        end
      end
    end
  end

endmodule
